// File: rtl/rdc_pkg.sv
// Shared types and helpers for the request duration counter.
// Combinational helpers only: no latency and no flow control.
package rdc_pkg;

  typedef enum logic {
    RDC_PULSE = 1'b0,
    RDC_ACCUM = 1'b1
  } rdc_mode_e;

  localparam int SAT_W = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/rdc_event_counter.sv
// One event: pulse-length or windowed-accumulate counter, threshold compare, high watermark.
// Latency: exceed_o is combinational on the registered count; no backpressure, samples every cycle.
module rdc_event_counter
  import rdc_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int WEIGHTS_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     event_i,
  input  rdc_mode_e                mode_i,
  input  logic                     win_end_i,
  input  logic [WEIGHTS_WIDTH-1:0] weight_i,
  input  logic                     clear_wm_i,
  output logic                     exceed_o,
  output logic [CNT_WIDTH-1:0]     wm_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] wm_q;
  rdc_mode_e            mode_q;

  assign cnt_inc = CNT_WIDTH'(sat_inc(SAT_W'(cnt_q), CNT_WIDTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      mode_q <= RDC_PULSE;
    end else begin
      mode_q <= mode_i;
      // A mode switch restarts counting so the two metrics never mix.
      if (!enable_i || (mode_i != mode_q)) begin
        cnt_q <= '0;
      end else if (mode_i == RDC_PULSE) begin
        cnt_q <= event_i ? cnt_inc : '0;
      end else if (win_end_i) begin
        cnt_q <= event_i ? CNT_WIDTH'(1) : '0;
      end else if (event_i) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_wm_i) begin
      wm_q <= '0;
    end else if (enable_i && (cnt_q > wm_q)) begin
      wm_q <= cnt_q;
    end
  end

  assign exceed_o = (weight_i != '0) && (cnt_q >= CNT_WIDTH'(weight_i));
  assign wm_o     = wm_q;

endmodule

// File: rtl/rdc_multimode.sv
// Multi-mode request duration counter: per-event counters, sticky irq vector, first-offender capture.
// Latency: irq is combinational on registered counts; no backpressure, events sampled every cycle.
module rdc_multimode
  import rdc_pkg::*;
#(
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int WINDOW_WIDTH  = 16
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   enable_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]                    events_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0][WEIGHTS_WIDTH-1:0] events_weights_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]                    mode_i,
  input  logic [WINDOW_WIDTH-1:0]                                window_len_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]                    clear_irq_i,
  input  logic                                                   clear_wm_i,
  output logic                                                   interruption_rdc_o,
  output logic [N_CORES-1:0][CORE_EVENTS-1:0]                    interruption_vector_rdc_o,
  output logic [N_CORES-1:0][CORE_EVENTS-1:0][CNT_WIDTH-1:0]     watermark_o,
  output logic                                                   first_valid_o,
  output logic [idx_width(N_CORES*CORE_EVENTS)-1:0]              first_id_o
);

  localparam int N_CNT = N_CORES * CORE_EVENTS;
  localparam int IDX_W = idx_width(N_CNT);

  logic [WINDOW_WIDTH-1:0] win_cnt_q;
  logic                    win_end;
  logic [N_CNT-1:0]        exceed;
  logic [N_CNT-1:0]        vec_q;
  logic [N_CNT-1:0]        clr_flat;
  logic                    first_vld_q;
  logic [IDX_W-1:0]        first_id_q;
  logic [IDX_W-1:0]        first_sel;

  assign win_end = enable_i && (window_len_i != '0)
                   && (win_cnt_q == window_len_i - WINDOW_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || win_end) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + WINDOW_WIDTH'(1);
    end
  end

  for (genvar x = 0; x < N_CORES; x++) begin : g_core
    for (genvar y = 0; y < CORE_EVENTS; y++) begin : g_evt
      rdc_event_counter #(
        .CNT_WIDTH     (CNT_WIDTH),
        .WEIGHTS_WIDTH (WEIGHTS_WIDTH)
      ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .event_i    (events_i[x][y]),
        .mode_i     (rdc_mode_e'(mode_i[x][y])),
        .win_end_i  (win_end),
        .weight_i   (events_weights_i[x][y]),
        .clear_wm_i (clear_wm_i),
        .exceed_o   (exceed[x*CORE_EVENTS+y]),
        .wm_o       (watermark_o[x][y])
      );
    end
  end

  assign clr_flat = clear_irq_i;

  // Set wins over a same-cycle clear, so a still-offending event cannot be silenced.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      vec_q <= '0;
    end else begin
      vec_q <= (vec_q & ~clr_flat) | exceed;
    end
  end

  always_comb begin
    first_sel = '0;
    for (int k = N_CNT - 1; k >= 0; k--) begin
      if (exceed[k]) first_sel = IDX_W'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      first_vld_q <= 1'b0;
      first_id_q  <= '0;
    end else if (!first_vld_q && (|exceed)) begin
      first_vld_q <= 1'b1;
      first_id_q  <= first_sel;
    end
  end

  assign interruption_rdc_o        = enable_i && ((|exceed) || (|vec_q));
  assign interruption_vector_rdc_o = vec_q;
  assign first_valid_o             = first_vld_q;
  assign first_id_o                = first_id_q;

endmodule

// File: tb/tb_rdc_multimode.sv
// Directed bench: stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_rdc_multimode;

  localparam int NC = 4, CE = 2, WW = 8, CW = 16, WINW = 16;
  localparam int SEL_IRQ = 0, SEL_VEC = 1, SEL_WM = 2, SEL_FV = 3, SEL_FID = 4,
                 SEL_CNT0 = 5, SEL_SEEN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, en, clr_wm;
  logic [NC-1:0][CE-1:0]         ev, mode, clr;
  logic [NC-1:0][CE-1:0][WW-1:0] wgt;
  logic [WINW-1:0]               win_len;
  logic                          irq, fv;
  logic [NC-1:0][CE-1:0]         vec;
  logic [NC-1:0][CE-1:0][CW-1:0] wm;
  logic [2:0]                    fid;
  logic [CW-1:0]                 cnt00;
  logic                          irq_seen = 1'b0;

  rdc_multimode #(
    .N_CORES(NC), .CORE_EVENTS(CE), .WEIGHTS_WIDTH(WW), .CNT_WIDTH(CW), .WINDOW_WIDTH(WINW)
  ) u_dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .enable_i                  (en),
    .events_i                  (ev),
    .events_weights_i          (wgt),
    .mode_i                    (mode),
    .window_len_i              (win_len),
    .clear_irq_i               (clr),
    .clear_wm_i                (clr_wm),
    .interruption_rdc_o        (irq),
    .interruption_vector_rdc_o (vec),
    .watermark_o               (wm),
    .first_valid_o             (fv),
    .first_id_o                (fid)
  );

  assign cnt00 = u_dut.g_core[0].g_evt[0].u_cnt.cnt_q;

  typedef struct {
    int          cyc;
    int          sel;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act_of(input int sel, input int idx);
    case (sel)
      SEL_IRQ:  return 32'(irq);
      SEL_VEC:  return 32'(vec);
      SEL_WM:   return 32'(wm[idx/CE][idx%CE]);
      SEL_FV:   return 32'(fv);
      SEL_FID:  return 32'(fid);
      SEL_CNT0: return 32'(cnt00);
      SEL_SEEN: return 32'(irq_seen);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = sb.pop_front();
      a = act_of(e.sel, e.idx);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.exp, cyc);
      end
    end
  end

  // Expectation for the state after the next rising edge, with current inputs held.
  task automatic expect_eq(input string name, input int sel, input int idx, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + 1; e.sel = sel; e.idx = idx; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr_wm = 1'b0; ev = '0; mode = '0; clr = '0; win_len = '0;
    wgt = '0;
    wgt[0][0] = 8'd5; wgt[1][0] = 8'd6; wgt[1][1] = 8'd2; wgt[2][1] = 8'd3; wgt[3][0] = 8'd2;

    // Reset state
    tick();
    expect_eq("rst_irq", SEL_IRQ, 0, 0);
    expect_eq("rst_vec", SEL_VEC, 0, 0);
    expect_eq("rst_wm0", SEL_WM, 0, 0);
    expect_eq("rst_fv",  SEL_FV, 0, 0);
    expect_eq("rst_fid", SEL_FID, 0, 0);
    tick();

    // Pulse mode on k=0, weight 5
    rst = 1'b0; en = 1'b1; ev[0][0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) expect_eq("t1_cnt4_no_irq", SEL_IRQ, 0, 0);
      tick();
    end
    ev[0][0] = 1'b0;
    expect_eq("t1_wm4", SEL_WM, 0, 4);
    expect_eq("t1_vec0", SEL_VEC, 0, 0);
    tick();
    ev[0][0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) expect_eq("t1_cnt4_irq_low", SEL_IRQ, 0, 0);
      if (i == 5) begin
        expect_eq("t1_irq_at_5", SEL_IRQ, 0, 1);
        expect_eq("t1_vec_lags", SEL_VEC, 0, 0);
      end
      tick();
    end
    ev[0][0] = 1'b0;
    expect_eq("t1_vec_set", SEL_VEC, 0, 32'h01);
    expect_eq("t1_wm5", SEL_WM, 0, 5);
    expect_eq("t1_irq_sticky", SEL_IRQ, 0, 1);
    expect_eq("t1_fv", SEL_FV, 0, 1);
    expect_eq("t1_fid", SEL_FID, 0, 0);
    tick();
    clr[0][0] = 1'b1;
    expect_eq("t1_clear_vec", SEL_VEC, 0, 0);
    expect_eq("t1_clear_irq", SEL_IRQ, 0, 0);
    tick();
    clr = '0;

    // Accumulate mode on k=2, window 10, weight 6
    en = 1'b0; mode[1][0] = 1'b1; win_len = 16'd10;
    tick();
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ev[1][0] = (i % 2 == 1);
      if (i == 9) begin
        expect_eq("t2_peak5_no_irq", SEL_IRQ, 0, 0);
        expect_eq("t2_wm_lag4", SEL_WM, 2, 4);
      end
      if (i == 10) begin
        expect_eq("t2_win_end_wm5", SEL_WM, 2, 5);
        expect_eq("t2_win_end_irq", SEL_IRQ, 0, 0);
      end
      tick();
    end
    ev[1][0] = 1'b1;
    for (int i = 11; i <= 16; i++) begin
      if (i == 15) expect_eq("t2_cnt5_irq_low", SEL_IRQ, 0, 0);
      if (i == 16) expect_eq("t2_cnt6_irq", SEL_IRQ, 0, 1);
      tick();
    end
    ev[1][0] = 1'b0;
    tick();

    // Sticky clear on k=5 ([2][1]), weight 3
    en = 1'b0;
    tick();
    en = 1'b1; ev[2][1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) expect_eq("t4_irq_at_3", SEL_IRQ, 0, 1);
      tick();
    end
    clr[2][1] = 1'b1;
    expect_eq("t4_set_wins", SEL_VEC, 0, 32'h20);
    tick();
    clr = '0; ev[2][1] = 1'b0;
    expect_eq("t4_vec_held", SEL_VEC, 0, 32'h20);
    expect_eq("t4_irq_held", SEL_IRQ, 0, 1);
    tick();
    clr[2][1] = 1'b1;
    expect_eq("t4_vec_cleared", SEL_VEC, 0, 0);
    expect_eq("t4_irq_cleared", SEL_IRQ, 0, 0);
    expect_eq("t4_fid5", SEL_FID, 0, 5);
    tick();
    clr = '0;

    // Simultaneous offenders k=6 and k=3, then later k=0
    en = 1'b0;
    tick();
    en = 1'b1; ev[3][0] = 1'b1; ev[1][1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) expect_eq("t5_fv_not_yet", SEL_FV, 0, 0);
      if (i == 3) begin
        expect_eq("t5_fv", SEL_FV, 0, 1);
        expect_eq("t5_fid3", SEL_FID, 0, 3);
      end
      tick();
    end
    ev[3][0] = 1'b0; ev[1][1] = 1'b0; ev[0][0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        expect_eq("t5_vec_49", SEL_VEC, 0, 32'h49);
        expect_eq("t5_fid_kept", SEL_FID, 0, 3);
      end
      tick();
    end

    // Mode flip, disable, clear watermark, mid-run reset
    mode[0][0] = 1'b1;
    expect_eq("t6_flip_cnt0", SEL_CNT0, 0, 0);
    expect_eq("t6_wm6", SEL_WM, 0, 6);
    tick();
    en = 1'b0;
    expect_eq("t6_dis_wm_held", SEL_WM, 0, 6);
    expect_eq("t6_dis_vec", SEL_VEC, 0, 0);
    expect_eq("t6_dis_fv", SEL_FV, 0, 0);
    expect_eq("t6_dis_cnt", SEL_CNT0, 0, 0);
    expect_eq("t6_dis_irq", SEL_IRQ, 0, 0);
    tick();
    en = 1'b1;
    for (int i = 1; i <= 3; i++) tick();
    clr_wm = 1'b1;
    expect_eq("t6_clear_wm", SEL_WM, 0, 0);
    tick();
    clr_wm = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) expect_eq("t6_pre_rst_fv", SEL_FV, 0, 1);
      tick();
    end
    rst = 1'b1;
    expect_eq("t6_rst_cnt", SEL_CNT0, 0, 0);
    expect_eq("t6_rst_wm", SEL_WM, 0, 0);
    expect_eq("t6_rst_vec", SEL_VEC, 0, 0);
    expect_eq("t6_rst_irq", SEL_IRQ, 0, 0);
    expect_eq("t6_rst_fv", SEL_FV, 0, 0);
    tick();

    // Saturation on k=7 with weight 0
    rst = 1'b0; ev = '0; mode = '0; ev[3][1] = 1'b1; irq_seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (irq) irq_seen = 1'b1;
    end
    expect_eq("t3_wm_sat", SEL_WM, 7, 16'hFFFF);
    expect_eq("t3_no_irq", SEL_SEEN, 0, 0);
    tick();

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
